seg_dynamic_scan: RTL and testbench
===================================

# seg_dynamic_scan

Six-digit multiplexed seven-segment driver for the board's common-anode display. It takes a binary value from the application logic and converts it to BCD with a sequential shift-and-add-3 engine. It applies leading-zero blanking, decimal point and minus sign, then scans the six digits at 1 ms per digit. It replaces single-digit static driving as the stage that directly drives the `sel`/`seg` pins.

## Interface

Parameters:
- `CNT_MAX`, 16'd49_999: digit dwell counter terminal value; 1 ms per digit at 50 MHz.

Ports:
- `sys_clk` in 1: system clock, 50 MHz.
- `sys_rst` in 1: asynchronous, active-high reset.
- `data` in 20: unsigned value to display.
  - Values above 999_999 are clamped to 999_999.
- `point` in 6: decimal point enables, one bit per digit.
  - Bit i is the dp of digit i; digit 0 is rightmost.
- `sign` in 1: 1 means the value is displayed as negative (magnitude in `data`).
- `seg_en` in 1: 1 enables the display; 0 blanks it.
- `sel` out 6: digit select, one-hot, active-high; `sel[0]` is the rightmost digit.
- `seg` out 8: segment drive, active-low.
  - Bit 7 is dp; bits 6..0 are g..a.

## Operation

- Input capture:
  - `data`, `point` and `sign` are sampled into shadow registers when the converter is IDLE and any of them differs from the shadow copy.
  - The converter is started on that same cycle.
- Converter FSM states:
  - IDLE → SHIFT: on start.
  - SHIFT: 20 iterations. Each cycle, every BCD nibble ≥ 5 gets +3, then {bcd[23:0], bin[19:0]} shifts left by 1.
  - SHIFT → DONE: after iteration 20.
  - DONE → IDLE: one cycle later.
  - In DONE the 24-bit BCD result, the shadow `point` and the shadow `sign` load atomically into the display register. The display never shows a half-converted value.
- Input change during SHIFT: the current conversion finishes with the old sample. The new value is captured on the first IDLE cycle after DONE.
- Digit code table: 0–9 use the standard active-low codes (0 = 8'b1100_0000, 1 = 8'b1111_1001, …, 9 = 8'b1001_0000).
- Blank code: 8'hFF.
- Minus code: 8'b1011_1111.
- Leading-zero blanking:
  - Let H be the index of the highest nonzero BCD digit, raised to the index of the highest set `point` bit. H = 0 if both are zero.
  - Digits above H are blank. Digit 0 is always shown.
- Sign:
  - If `sign` = 1 and H < 5, digit H+1 shows minus.
  - If H = 5, the sign is dropped.
  - Zero with `sign` = 1 shows "-0".
- dp: `seg[7]` = ~point_shadow[i] for the displayed digit i, including blank and minus positions.
- Scan:
  - `cnt_1ms` counts 0..CNT_MAX and wraps.
  - A one-cycle `scan_flag` pulses when `cnt_1ms` == CNT_MAX−1.
  - On `scan_flag`, the digit index advances 0→1→…→5→0.
- `seg_en` = 0: `sel` = 6'b000000 and `seg` = 8'hFF. The counters, index and converter keep running.

## Timing

- Reset values:
  - `sel` = 6'b000000, `seg` = 8'hFF.
  - `cnt_1ms` = 0, index = 0.
  - FSM = IDLE; shadows and display register = 0.
- The first conversion starts on the first cycle after reset whose inputs differ from zero.
- Conversion latency: input change to display register updated = 22 cycles (1 capture + 20 shift + 1 DONE).
- `sel` and `seg` are both registered and change on the same edge, one cycle after `scan_flag`. They are never misaligned.
- Full scan period: 6 × (CNT_MAX+1) cycles.
- Reset asserted mid-conversion or mid-scan: immediate abort to reset values. No partial result is loaded.

## Structure

- Shared package `seg_pkg`:
  - Constants SEG_0..SEG_9, SEG_A..SEG_F, SEG_NEG, IDLE (8'hFF).
  - Digit count 6.
- Sub-module `bin2bcd`:
  - Ports: `sys_clk`, `sys_rst`, `start`, `bin[19:0]`, `busy`, `done`, `bcd[23:0]`.
  - Contains the IDLE/SHIFT/DONE FSM and the iteration counter.
- The top level holds the input capture, clamp, blanking/sign logic, scan counter and output registers.

## Test plan

1. Reset held 10 cycles, then released with `data` = 0 and `seg_en` = 1.
   - During reset: `sel` = 000000, `seg` = FF.
   - After release: digit 0 shows 8'hC0 and digits 1–5 show FF.
2. `data` = 123456, `point` = 0.
   - Display register updates exactly 22 cycles after the change.
   - The scan shows 6,5,4,3,2,1 on `sel` = 000001..100000, each held CNT_MAX+1 cycles.
3. `data` = 42, `point` = 6'b000100, `sign` = 1.
   - Digits 0–2 show "042", with the dp on digit 2 (seg = 8'h40).
   - Digit 3 shows minus (8'hBF); digits 4–5 show FF.
4. `data` = 1_048_575 (clamped), `sign` = 1.
   - All six digits show 9 (8'h90); no minus.
5. `data` changed at cycle 5 of a conversion.
   - The old value is displayed first.
   - The new value appears 22 cycles after the first conversion's DONE.
6. `seg_en` = 0 for 3 ms, and `sys_rst` is pulsed during SHIFT.
   - While `seg_en` = 0: `sel` = 000000 and `seg` = FF, and the digit index keeps advancing.
   - On the reset pulse: outputs return to reset values and the display register stays 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the six-digit seven-segment driver: active-low segment codes, digit count, converter states.
// Latency: none (pure declarations). Backpressure: none.
package seg_pkg;

  localparam int DIGIT_NUM = 6;
  localparam logic [2:0] LAST_DIGIT = 3'd5;

  // active-low, bit 7 = dp, bits 6..0 = g..a
  localparam logic [7:0] SEG_0   = 8'b1100_0000;
  localparam logic [7:0] SEG_1   = 8'b1111_1001;
  localparam logic [7:0] SEG_2   = 8'b1010_0100;
  localparam logic [7:0] SEG_3   = 8'b1011_0000;
  localparam logic [7:0] SEG_4   = 8'b1001_1001;
  localparam logic [7:0] SEG_5   = 8'b1001_0010;
  localparam logic [7:0] SEG_6   = 8'b1000_0010;
  localparam logic [7:0] SEG_7   = 8'b1111_1000;
  localparam logic [7:0] SEG_8   = 8'b1000_0000;
  localparam logic [7:0] SEG_9   = 8'b1001_0000;
  localparam logic [7:0] SEG_A   = 8'b1000_1000;
  localparam logic [7:0] SEG_B   = 8'b1000_0011;
  localparam logic [7:0] SEG_C   = 8'b1100_0110;
  localparam logic [7:0] SEG_D   = 8'b1010_0001;
  localparam logic [7:0] SEG_E   = 8'b1000_0110;
  localparam logic [7:0] SEG_F   = 8'b1000_1110;
  localparam logic [7:0] SEG_NEG = 8'b1011_1111;
  localparam logic [7:0] IDLE    = 8'hFF;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} conv_state_t;

  function automatic logic [7:0] seg_code(input logic [3:0] nib);
    case (nib)
      4'h0: seg_code = SEG_0;
      4'h1: seg_code = SEG_1;
      4'h2: seg_code = SEG_2;
      4'h3: seg_code = SEG_3;
      4'h4: seg_code = SEG_4;
      4'h5: seg_code = SEG_5;
      4'h6: seg_code = SEG_6;
      4'h7: seg_code = SEG_7;
      4'h8: seg_code = SEG_8;
      4'h9: seg_code = SEG_9;
      4'hA: seg_code = SEG_A;
      4'hB: seg_code = SEG_B;
      4'hC: seg_code = SEG_C;
      4'hD: seg_code = SEG_D;
      4'hE: seg_code = SEG_E;
      default: seg_code = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg_dynamic_scan_bin2bcd.sv
// Sequential shift-and-add-3 converter, 20-bit binary to 6-digit BCD.
// Latency: start to done = 21 cycles (20 shifts, then DONE for one cycle); start ignored while busy.
module bin2bcd
  import seg_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [19:0] bin,
  output logic        busy,
  output logic        done,
  output logic [23:0] bcd
);

  conv_state_t state;
  logic [19:0] bin_r;
  logic [23:0] bcd_r;
  logic [23:0] bcd_adj;
  logic [4:0]  iter;

  always_comb begin
    bcd_adj = bcd_r;
    for (int i = 0; i < DIGIT_NUM; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= S_IDLE;
      bin_r <= '0;
      bcd_r <= '0;
      iter  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            bin_r <= bin;
            bcd_r <= '0;
            iter  <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {bcd_r, bin_r} <= {bcd_adj, bin_r} << 1;
          iter <= iter + 5'd1;
          if (iter == 5'd19) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign bcd  = bcd_r;

endmodule

// File: rtl/seg_dynamic_scan.sv
// Six-digit multiplexed seven-segment driver: capture, BCD convert, blank/sign/dp, 1 ms-per-digit scan.
// Latency: input change to display register 22 cycles; sel/seg registered. No backpressure; changes during a conversion wait for the next IDLE.
module seg_dynamic_scan
  import seg_pkg::*;
#(
  parameter logic [15:0] CNT_MAX = 16'd49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        sign,
  input  logic        seg_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  logic [19:0] data_sh;
  logic [5:0]  point_sh;
  logic        sign_sh;
  logic        busy, done, start;
  logic [19:0] bin;
  logic [23:0] bcd;
  logic [23:0] disp_bcd;
  logic [5:0]  disp_point;
  logic        disp_sign;
  logic [15:0] cnt_1ms;
  logic        scan_flag;
  logic [2:0]  idx;
  logic [2:0]  hi;
  logic [3:0]  nib;
  logic        dp;
  logic [7:0]  code;

  assign start = !busy && ({data, point, sign} != {data_sh, point_sh, sign_sh});
  assign bin   = (data > 20'd999_999) ? 20'd999_999 : data;

  bin2bcd u_bin2bcd (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd)
  );

  // point/sign ride with the BCD result so the display updates atomically
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      data_sh    <= '0;
      point_sh   <= '0;
      sign_sh    <= 1'b0;
      disp_bcd   <= '0;
      disp_point <= '0;
      disp_sign  <= 1'b0;
    end else begin
      if (start) begin
        data_sh  <= data;
        point_sh <= point;
        sign_sh  <= sign;
      end
      if (done) begin
        disp_bcd   <= bcd;
        disp_point <= point_sh;
        disp_sign  <= sign_sh;
      end
    end
  end

  assign scan_flag = (cnt_1ms == CNT_MAX - 16'd1);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_1ms <= '0;
      idx     <= '0;
    end else begin
      cnt_1ms <= (cnt_1ms == CNT_MAX) ? 16'd0 : cnt_1ms + 16'd1;
      if (scan_flag) idx <= (idx == LAST_DIGIT) ? 3'd0 : idx + 3'd1;
    end
  end

  // highest digit kept visible: top nonzero digit or top dp, whichever is higher
  always_comb begin
    hi  = '0;
    nib = '0;
    dp  = 1'b0;
    for (int i = 1; i < DIGIT_NUM; i++) begin
      if (disp_bcd[4*i +: 4] != 4'd0 || disp_point[i]) hi = 3'(i);
    end
    for (int i = 0; i < DIGIT_NUM; i++) begin
      if (idx == 3'(i)) begin
        nib = disp_bcd[4*i +: 4];
        dp  = disp_point[i];
      end
    end
    if (idx <= hi)                         code = seg_code(nib);
    else if (disp_sign && idx == hi + 3'd1) code = SEG_NEG;
    else                                   code = IDLE;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel <= '0;
      seg <= IDLE;
    end else if (seg_en) begin
      sel <= 6'b000001 << idx;
      seg <= {~dp, code[6:0]};
    end else begin
      sel <= '0;
      seg <= IDLE;
    end
  end

endmodule

// File: tb/tb_seg_dynamic_scan.sv
// Directed bench for seg_dynamic_scan with a display scoreboard and short digit dwell.
module tb_seg_dynamic_scan;

  localparam logic [15:0] CNT_MAX = 16'd9;
  localparam int DWELL = 10;

  logic        sys_clk;
  logic        sys_rst;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string      tag;
    logic [5:0] sel;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];
  logic [7:0] tbl [10];

  seg_dynamic_scan #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .data    (data),
    .point   (point),
    .sign    (sign),
    .seg_en  (seg_en),
    .sel     (sel),
    .seg     (seg)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] model_digit(input int v, input logic [5:0] p, input logic s, input int i);
    int dig[6];
    int t;
    int h;
    logic [7:0] c;
    t = (v > 999999) ? 999999 : v;
    for (int k = 0; k < 6; k++) begin
      dig[k] = t % 10;
      t = t / 10;
    end
    h = 0;
    for (int k = 0; k < 6; k++) if (dig[k] != 0 || p[k]) h = k;
    if (i <= h) c = tbl[dig[i]];
    else if (s && i == h + 1) c = 8'hBF;
    else c = 8'hFF;
    return {~p[i], c[6:0]};
  endfunction

  task automatic push_display(input string tag, input int v, input logic [5:0] p, input logic s);
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      e.tag = $sformatf("%s_d%0d", tag, i);
      e.sel = 6'b000001 << i;
      e.seg = model_digit(v, p, s, i);
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    exp_t e;
    int n;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n = 0;
      while (sel !== e.sel && n < 8 * DWELL) begin
        @(negedge sys_clk);
        n++;
      end
      check(e.tag, {18'd0, sel, seg}, {18'd0, e.sel, e.seg});
    end
  endtask

  task automatic apply(input int v, input logic [5:0] p, input logic s);
    @(negedge sys_clk);
    data  = 20'(v);
    point = p;
    sign  = s;
  endtask

  initial begin
    int n;
    int d;
    logic [23:0] prev;
    logic [2:0] idx0, idx1;

    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    sys_rst = 1'b1;
    data    = '0;
    point   = '0;
    sign    = 1'b0;
    seg_en  = 1'b1;

    // reset held 10 cycles
    repeat (10) @(negedge sys_clk);
    check("rst_sel", {26'd0, sel}, 32'h0);
    check("rst_seg", {24'd0, seg}, 32'hFF);
    check("rst_disp", {8'd0, dut.disp_bcd}, 32'h0);
    sys_rst = 1'b0;
    push_display("zero", 0, 6'b0, 1'b0);
    drain();

    // 123456: latency and scan order
    @(negedge sys_clk);
    prev = dut.disp_bcd;
    data = 20'd123456;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge sys_clk);
      #1;
      if (dut.disp_bcd !== prev) begin
        n = k;
        break;
      end
    end
    check("lat_123456", n, 22);
    check("disp_123456", {8'd0, dut.disp_bcd}, 32'h123456);
    push_display("v123456", 123456, 6'b0, 1'b0);
    drain();

    @(negedge sys_clk);
    n = 0;
    while (sel === 6'b000001 && n < 8 * DWELL) begin @(negedge sys_clk); n++; end
    n = 0;
    while (sel !== 6'b000001 && n < 8 * DWELL) begin @(negedge sys_clk); n++; end
    d = 0;
    while (sel === 6'b000001 && d < 8 * DWELL) begin d++; @(negedge sys_clk); end
    check("dwell", d, DWELL);
    check("sel_next", {26'd0, sel}, 32'b000010);

    // 42 with dp on digit 2, negative
    apply(42, 6'b000100, 1'b1);
    repeat (30) @(negedge sys_clk);
    push_display("v42neg", 42, 6'b000100, 1'b1);
    drain();

    // clamp, sign dropped
    apply(1048575, 6'b0, 1'b1);
    repeat (30) @(negedge sys_clk);
    push_display("clamp", 1048575, 6'b0, 1'b1);
    drain();

    // change during SHIFT
    apply(1000, 6'b0, 1'b0);
    repeat (5) @(posedge sys_clk);
    #1;
    data = 20'd777777;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge sys_clk);
      #1;
      if (dut.disp_bcd === 24'h001000) begin
        n = k;
        break;
      end
    end
    check("old_first", n, 17);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge sys_clk);
      #1;
      if (dut.disp_bcd !== 24'h001000) begin
        n = k;
        break;
      end
    end
    check("new_lat", n, 22);
    check("new_val", {8'd0, dut.disp_bcd}, 32'h777777);
    push_display("v777777", 777777, 6'b0, 1'b0);
    drain();

    // seg_en low for 3 dwells
    @(negedge sys_clk);
    seg_en = 1'b0;
    idx0 = dut.idx;
    for (int k = 1; k <= 3 * DWELL; k++) begin
      @(negedge sys_clk);
      if (k % 5 == 0) check($sformatf("blank_%0d", k), {18'd0, sel, seg}, {18'd0, 6'b0, 8'hFF});
    end
    idx1 = dut.idx;
    check("idx_adv", (int'(idx1) - int'(idx0) + 6) % 6, 3);
    seg_en = 1'b1;

    // reset pulse during SHIFT
    apply(31415, 6'b0, 1'b0);
    repeat (5) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    #1;
    check("rp_sel", {26'd0, sel}, 32'h0);
    check("rp_seg", {24'd0, seg}, 32'hFF);
    check("rp_disp", {8'd0, dut.disp_bcd}, 32'h0);
    check("rp_idx", {29'd0, dut.idx}, 32'h0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rp_disp_after", {8'd0, dut.disp_bcd}, 32'h0);
    repeat (30) @(negedge sys_clk);
    push_display("v31415", 31415, 6'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
